// File: rtl/gfx256_pkg.sv
// Shared types and constants for the gfx256 fragment path.
package gfx256_pkg;

   // Width of the x/y/z/u/v and bezier factor fields.
   localparam int point_width_c = 16;

   // One interpolated fragment as it travels from the interpolator to the
   // fragment processor. z is a signed depth, carried here as opaque bits.
   typedef struct packed {
      logic [point_width_c-1:0] x;
      logic [point_width_c-1:0] y;
      logic [point_width_c-1:0] z;
      logic [point_width_c-1:0] u;
      logic [point_width_c-1:0] v;
      logic [point_width_c-1:0] bezier0;
      logic [point_width_c-1:0] bezier1;
      logic [7:0]               a;
      logic [31:0]              color;
   } gfx256_fragment_t;

   localparam int fragment_width_c = $bits(gfx256_fragment_t);

   // Bundles the individual interpolator fields into one fragment.
   function automatic gfx256_fragment_t make_fragment(
      input logic [point_width_c-1:0] x,
      input logic [point_width_c-1:0] y,
      input logic [point_width_c-1:0] z,
      input logic [point_width_c-1:0] u,
      input logic [point_width_c-1:0] v,
      input logic [point_width_c-1:0] bezier0,
      input logic [point_width_c-1:0] bezier1,
      input logic [7:0]               a,
      input logic [31:0]              color
   );
      gfx256_fragment_t f;
      f.x       = x;
      f.y       = y;
      f.z       = z;
      f.u       = u;
      f.v       = v;
      f.bezier0 = bezier0;
      f.bezier1 = bezier1;
      f.a       = a;
      f.color   = color;
      return f;
   endfunction

endpackage

// File: rtl/gfx256_frag_fifo.sv
// Synchronous show-ahead FIFO of fragments with push, pop, clear and level.
// depth must be a power of two (>= 2) so the pointers wrap naturally.
module gfx256_frag_fifo
   import gfx256_pkg::*;
#(
   parameter  int depth   = 4,
   localparam int ptr_w   = $clog2(depth),
   localparam int level_w = ptr_w + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               push,
   input  gfx256_fragment_t   push_data,
   input  logic               pop,
   output gfx256_fragment_t   head,
   output logic [level_w-1:0] level,
   output logic               full,
   output logic               empty
);

   localparam logic [level_w-1:0] depth_lv = level_w'(depth);

   gfx256_fragment_t   mem [depth];
   logic [ptr_w-1:0]   wr_ptr;
   logic [ptr_w-1:0]   rd_ptr;
   logic               push_en;
   logic               pop_en;

   assign full    = (level == depth_lv);
   assign empty   = (level == '0);
   // Clear wins over both operations; the entries it discards are simply
   // forgotten by resetting the pointers.
   assign push_en = push && !full  && !clear;
   assign pop_en  = pop  && !empty && !clear;
   assign head    = mem[rd_ptr];

   // Store the incoming fragment at the write pointer.
   // NOTE: the storage array has no reset; an entry is only ever read after
   // it has been written, and leaving it unreset lets it map onto RAM.
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Advance pointers and track occupancy; pointers wrap modulo depth.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_en, pop_en})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/gfx256_frag_queue.sv
// Responder end of the interpolator write/ack handshake; buffers fragments
// and presents them on a valid/ready interface to the fragment processor.
module gfx256_frag_queue
   import gfx256_pkg::*;
#(
   parameter  int point_width = point_width_c,
   parameter  int fifo_depth  = 4,
   localparam int level_w     = $clog2(fifo_depth) + 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   input  logic                   write_i,
   output logic                   ack_o,
   input  logic [point_width-1:0] x_i,
   input  logic [point_width-1:0] y_i,
   input  logic [point_width-1:0] z_i,
   input  logic [point_width-1:0] u_i,
   input  logic [point_width-1:0] v_i,
   input  logic [7:0]             a_i,
   input  logic [31:0]            color_i,
   input  logic [point_width-1:0] bezier_factor0_i,
   input  logic [point_width-1:0] bezier_factor1_i,
   output logic                   frag_valid_o,
   input  logic                   frag_ready_i,
   output logic [point_width-1:0] x_o,
   output logic [point_width-1:0] y_o,
   output logic [point_width-1:0] z_o,
   output logic [point_width-1:0] u_o,
   output logic [point_width-1:0] v_o,
   output logic [7:0]             a_o,
   output logic [31:0]            color_o,
   output logic [point_width-1:0] bezier_factor0_o,
   output logic [point_width-1:0] bezier_factor1_o,
   output logic [level_w-1:0]     level_o
);

   logic               ack;
   logic               capture;
   logic               pop;
   logic               full;
   logic               empty;
   gfx256_fragment_t   in_frag;
   gfx256_fragment_t   head;
   gfx256_fragment_t   out_frag;

   assign in_frag = make_fragment(x_i, y_i, z_i, u_i, v_i,
                                  bezier_factor0_i, bezier_factor1_i,
                                  a_i, color_i);

   // The interpolator still holds write_i during the ack cycle, so a write
   // seen while ack is high is the same fragment and must not be taken again.
   // Fullness uses the registered level: a same-edge pop does not free a slot.
   assign capture = write_i && !ack && !full && !flush_i;
   assign pop     = frag_valid_o && frag_ready_i;

   // One-cycle accept pulse per captured fragment.
   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge values, independent of block ordering.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ack <= 1'b0;
      end else begin
         ack <= capture;
      end
   end

   assign ack_o = ack;

   gfx256_frag_fifo #(
      .depth (fifo_depth)
   ) u_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .clear     (flush_i),
      .push      (capture),
      .push_data (in_frag),
      .pop       (pop),
      .head      (head),
      .level     (level_o),
      .full      (full),
      .empty     (empty)
   );

   assign frag_valid_o = !empty;

   // Payload is forced to zero whenever no fragment is presented.
   always_comb begin
      out_frag = '0;
      if (frag_valid_o) begin
         out_frag = head;
      end
   end

   assign x_o              = out_frag.x;
   assign y_o              = out_frag.y;
   assign z_o              = out_frag.z;
   assign u_o              = out_frag.u;
   assign v_o              = out_frag.v;
   assign a_o              = out_frag.a;
   assign color_o          = out_frag.color;
   assign bezier_factor0_o = out_frag.bezier0;
   assign bezier_factor1_o = out_frag.bezier1;

endmodule

// File: tb/tb_gfx256_frag_queue.sv
// Self-checking bench for gfx256_frag_queue: directed steps, interpolator
// drop-after-ack model and a scoreboard checked at each output pop.
module tb_gfx256_frag_queue;
   import gfx256_pkg::*;

   localparam int pw = point_width_c;
   localparam int lw = 3;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          flush_i = 1'b0;
   logic          write_i = 1'b0;
   logic          ack_o;
   logic [pw-1:0] x_i = '0, y_i = '0, z_i = '0, u_i = '0, v_i = '0;
   logic [7:0]    a_i = '0;
   logic [31:0]   color_i = '0;
   logic [pw-1:0] bezier_factor0_i = '0, bezier_factor1_i = '0;
   logic          frag_valid_o;
   logic          frag_ready_i = 1'b0;
   logic [pw-1:0] x_o, y_o, z_o, u_o, v_o;
   logic [7:0]    a_o;
   logic [31:0]   color_o;
   logic [pw-1:0] bezier_factor0_o, bezier_factor1_o;
   logic [lw-1:0] level_o;

   int vectors = 0;
   int miscompares = 0;
   int acks = 0;
   logic prev_ack = 1'b0;

   gfx256_fragment_t sb[$];
   gfx256_fragment_t cur;
   gfx256_fragment_t out_frag;

   always #5 clk = ~clk;

   gfx256_frag_queue #(.point_width(pw), .fifo_depth(4)) dut (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
      .write_i(write_i), .ack_o(ack_o),
      .x_i(x_i), .y_i(y_i), .z_i(z_i), .u_i(u_i), .v_i(v_i),
      .a_i(a_i), .color_i(color_i),
      .bezier_factor0_i(bezier_factor0_i), .bezier_factor1_i(bezier_factor1_i),
      .frag_valid_o(frag_valid_o), .frag_ready_i(frag_ready_i),
      .x_o(x_o), .y_o(y_o), .z_o(z_o), .u_o(u_o), .v_o(v_o),
      .a_o(a_o), .color_o(color_o),
      .bezier_factor0_o(bezier_factor0_o), .bezier_factor1_o(bezier_factor1_o),
      .level_o(level_o)
   );

   assign out_frag = make_fragment(x_o, y_o, z_o, u_o, v_o,
                                   bezier_factor0_o, bezier_factor1_o, a_o, color_o);

   task automatic check(input string tag,
                        input logic [fragment_width_c-1:0] obs,
                        input logic [fragment_width_c-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic gfx256_fragment_t mk(input int i);
      logic [15:0] k;
      k = 16'(i);
      return make_fragment(k, k * 16'd3 + 16'd1, 16'(-(i + 1)), k ^ 16'hA5A5,
                           16'h1000 + k, 16'h0F00 | k, ~k, 8'(i * 7),
                           {8'hC0, k, 8'(i)});
   endfunction

   task automatic drive(input gfx256_fragment_t f);
      cur              = f;
      x_i              = f.x;
      y_i              = f.y;
      z_i              = f.z;
      u_i              = f.u;
      v_i              = f.v;
      a_i              = f.a;
      color_i          = f.color;
      bezier_factor0_i = f.bezier0;
      bezier_factor1_i = f.bezier1;
      write_i          = 1'b1;
   endtask

   // Interpolator model: wait for ack, then drop write_i one edge later.
   task automatic wait_ack(input int budget, input bit drop_ready,
                           output logic [lw-1:0] lvl_at_ack,
                           output logic valid_at_ack);
      bit seen = 1'b0;
      lvl_at_ack   = '0;
      valid_at_ack = 1'b0;
      for (int n = 0; n < budget && !seen; n++) begin
         @(posedge clk); #1;
         if (ack_o) seen = 1'b1;
      end
      check("ack_within_budget", fragment_width_c'(seen), 1);
      if (seen) begin
         sb.push_back(cur);
         lvl_at_ack   = level_o;
         valid_at_ack = frag_valid_o;
         if (drop_ready) frag_ready_i = 1'b0;
      end
      @(posedge clk); #1;
      write_i = 1'b0;
   endtask

   task automatic drain();
      frag_ready_i = 1'b1;
      for (int n = 0; n < 32 && level_o != 0; n++) begin
         @(posedge clk); #1;
      end
      frag_ready_i = 1'b0;
      check("drain_level", fragment_width_c'(level_o), 0);
      check("drain_scoreboard_empty", fragment_width_c'(sb.size()), 0);
   endtask

   // Monitor: ack pulse shape, output order and payload masking.
   always @(negedge clk) begin
      if (rst_i) begin
         prev_ack = 1'b0;
      end else begin
         if (ack_o) begin
            acks++;
            check("ack_not_consecutive", fragment_width_c'(prev_ack), 0);
         end
         prev_ack = ack_o;
         if (frag_valid_o && frag_ready_i && !flush_i) begin
            check("pop_expected", fragment_width_c'(sb.size() > 0), 1);
            if (sb.size() > 0) check("head_payload", out_frag, sb.pop_front());
         end
         if (!frag_valid_o) check("payload_masked", out_frag, '0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [lw-1:0] lvl;
      logic          vld;
      int            acks_before;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_ack", fragment_width_c'(ack_o), 0);
      check("reset_valid", fragment_width_c'(frag_valid_o), 0);
      check("reset_level", fragment_width_c'(level_o), 0);
      check("reset_payload", out_frag, '0);
      rst_i = 1'b0;

      // Single fragment through an empty queue
      frag_ready_i = 1'b1;
      drive(make_fragment(16'd5, 16'd7, 16'hFFFD, 16'h0011, 16'h0022,
                          16'h0033, 16'h0044, 8'h80, 32'h00FF8040));
      wait_ack(4, 1'b0, lvl, vld);
      check("single_valid_at_ack", fragment_width_c'(vld), 1);
      check("single_level_at_ack", fragment_width_c'(lvl), 1);
      check("single_ack_one_cycle", fragment_width_c'(ack_o), 0);
      check("single_valid_next", fragment_width_c'(frag_valid_o), 0);
      check("single_level_back", fragment_width_c'(level_o), 0);

      // Back-to-back writes, x = 0..7
      acks_before = acks;
      for (int i = 0; i < 8; i++) begin
         drive(mk(i));
         wait_ack(4, 1'b0, lvl, vld);
      end
      drain();
      check("b2b_ack_count", fragment_width_c'(acks - acks_before), 8);

      // Full stall with a fifth pending write
      frag_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(mk(100 + i));
         wait_ack(4, 1'b0, lvl, vld);
      end
      check("full_level", fragment_width_c'(level_o), 4);
      drive(mk(104));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("full_no_ack", fragment_width_c'(ack_o), 0);
         check("full_level_held", fragment_width_c'(level_o), 4);
      end
      frag_ready_i = 1'b1;
      @(posedge clk); #1;
      frag_ready_i = 1'b0;
      check("full_pop_no_same_edge_ack", fragment_width_c'(ack_o), 0);
      check("full_level_after_pop", fragment_width_c'(level_o), 3);
      wait_ack(1, 1'b0, lvl, vld);
      check("full_level_after_refill", fragment_width_c'(lvl), 4);
      drain();

      // Simultaneous push and pop at level 2, ten fragments
      for (int i = 0; i < 2; i++) begin
         drive(mk(200 + i));
         wait_ack(4, 1'b0, lvl, vld);
      end
      for (int i = 2; i < 12; i++) begin
         frag_ready_i = 1'b1;
         drive(mk(200 + i));
         wait_ack(2, 1'b1, lvl, vld);
         check("pushpop_level_at_ack", fragment_width_c'(lvl), 2);
         check("pushpop_level_after", fragment_width_c'(level_o), 2);
      end
      drain();

      // Flush at level 3 with a pending write
      for (int i = 0; i < 3; i++) begin
         drive(mk(300 + i));
         wait_ack(4, 1'b0, lvl, vld);
      end
      check("flush_level_before", fragment_width_c'(level_o), 3);
      drive(mk(303));
      flush_i = 1'b1;
      @(posedge clk); #1;
      check("flush_level", fragment_width_c'(level_o), 0);
      check("flush_valid", fragment_width_c'(frag_valid_o), 0);
      check("flush_no_ack", fragment_width_c'(ack_o), 0);
      sb.delete();
      repeat (2) begin
         @(posedge clk); #1;
         check("flush_hold_no_ack", fragment_width_c'(ack_o), 0);
      end
      flush_i = 1'b0;
      wait_ack(1, 1'b0, lvl, vld);
      check("flush_after_level", fragment_width_c'(lvl), 1);
      drain();

      // Reset during the ack cycle with level 2
      drive(mk(400));
      wait_ack(4, 1'b0, lvl, vld);
      drive(mk(401));
      @(posedge clk); #1;
      check("rst_pre_ack", fragment_width_c'(ack_o), 1);
      check("rst_pre_level", fragment_width_c'(level_o), 2);
      rst_i = 1'b1;
      @(posedge clk); #1;
      check("rst_ack", fragment_width_c'(ack_o), 0);
      check("rst_valid", fragment_width_c'(frag_valid_o), 0);
      check("rst_level", fragment_width_c'(level_o), 0);
      check("rst_payload", out_frag, '0);
      write_i = 1'b0;
      sb.delete();
      rst_i = 1'b0;

      // Recovery after reset
      frag_ready_i = 1'b1;
      drive(mk(500));
      wait_ack(4, 1'b0, lvl, vld);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
